// File: rtl/spi_engine_pkg.sv
// Shared types and constants for the SPI clock burst engine.
// State encoding, default widths, mode-bit layout and the edge-to-strobe mapping.
package spi_engine_pkg;

  localparam int unsigned DIV_W_DEF = 8;
  localparam int unsigned CNT_W_DEF = 6;

  // Latched mode word layout: {cpol, cpha}
  localparam int unsigned MODE_W    = 2;
  localparam int unsigned MODE_CPOL = 1;
  localparam int unsigned MODE_CPHA = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_TAIL = 2'd2
  } state_e;

  typedef struct packed {
    logic shift;
    logic sample;
  } strobe_t;

  // Which strobe fires on an SCLK edge; the final trailing edge never shifts in mode cpha=0
  function automatic strobe_t edge_strobes(input logic cpha, input logic leading,
                                           input logic last);
    strobe_t s;
    if (cpha) begin
      s.shift  = leading;
      s.sample = ~leading;
    end else begin
      s.shift  = ~leading & ~last;
      s.sample = leading;
    end
    return s;
  endfunction

endpackage

// File: rtl/spi_sclk_engine_if.sv
// Control/status bundle between the frame sequencer (master) and the SCLK engine (slave).
interface spi_sclk_engine_if #(
  parameter int unsigned DIV_W = spi_engine_pkg::DIV_W_DEF,
  parameter int unsigned CNT_W = spi_engine_pkg::CNT_W_DEF
);

  logic             start;
  logic             stop;
  logic [DIV_W-1:0] clk_div;
  logic [CNT_W-1:0] num_bits;
  logic             cpol;
  logic             cpha;
  logic             sclk;
  logic             active;
  logic             shift_stb;
  logic             sample_stb;
  logic             done;

  modport master (
    output start, stop, clk_div, num_bits, cpol, cpha,
    input  sclk, active, shift_stb, sample_stb, done
  );

  modport slave (
    input  start, stop, clk_div, num_bits, cpol, cpha,
    output sclk, active, shift_stb, sample_stb, done
  );

endinterface

// File: rtl/spi_half_period_timer.sv
// Half-period counter: counts 0..term and ticks on the terminal count.
// load clears the count and captures the terminal value for the coming burst.
module spi_half_period_timer #(
  parameter int unsigned DIV_W = spi_engine_pkg::DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] term,
  output logic             tick_c
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] term_q, term_d;

  assign tick_c = en & (cnt_q == term_q);

  always_comb begin
    cnt_d  = cnt_q;
    term_d = term_q;
    if (load) begin
      cnt_d  = '0;
      term_d = term;
    end else if (en) begin
      cnt_d = tick_c ? '0 : cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      term_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      term_q <= term_d;
    end
  end

endmodule

// File: rtl/spi_sclk_engine.sv
// Burst SCLK generator for all four SPI modes on the system clock, with
// shift/sample strobes, a one-half-period tail hold, abort and a done pulse.
module spi_sclk_engine
  import spi_engine_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  spi_sclk_engine_if.slave   bus
);

  localparam int unsigned EDGE_W = CNT_W + 1;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    nbits_q, nbits_d;
  logic [MODE_W-1:0]   mode_q, mode_d;
  logic [EDGE_W-1:0]   edge_q, edge_d;
  logic                sclk_q, sclk_d;
  logic                active_q, active_d;
  logic                shift_q, shift_d;
  logic                sample_q, sample_d;
  logic                done_q, done_d;

  logic [EDGE_W-1:0]   edge_nxt_c;
  logic [EDGE_W-1:0]   two_n_c;
  logic                last_edge_c;
  strobe_t             stb_c;
  logic                tmr_load_c;
  logic                tmr_en_c;
  logic                tmr_tick_c;

  assign two_n_c     = {nbits_q, 1'b0};
  assign edge_nxt_c  = edge_q + EDGE_W'(1);
  assign last_edge_c = (edge_nxt_c == two_n_c);
  assign stb_c       = edge_strobes(mode_q[MODE_CPHA], edge_nxt_c[0], last_edge_c);

  spi_half_period_timer #(.DIV_W(DIV_W)) u_timer (
    .clk    (clk),
    .rst_n  (rst),
    .load   (tmr_load_c),
    .en     (tmr_en_c),
    .term   (bus.clk_div),
    .tick_c (tmr_tick_c)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    nbits_d    = nbits_q;
    mode_d     = mode_q;
    edge_d     = edge_q;
    sclk_d     = sclk_q;
    active_d   = active_q;
    shift_d    = 1'b0;
    sample_d   = 1'b0;
    done_d     = 1'b0;
    tmr_load_c = 1'b0;
    tmr_en_c   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        sclk_d   = bus.cpol;
        active_d = 1'b0;
        if (bus.start && !bus.stop && (bus.num_bits != '0)) begin
          state_d           = ST_RUN;
          nbits_d           = bus.num_bits;
          mode_d[MODE_CPOL] = bus.cpol;
          mode_d[MODE_CPHA] = bus.cpha;
          edge_d            = '0;
          active_d          = 1'b1;
          tmr_load_c        = 1'b1;
        end
      end

      ST_RUN: begin
        tmr_en_c = 1'b1;
        if (bus.stop) begin
          state_d  = ST_IDLE;
          sclk_d   = bus.cpol;
          active_d = 1'b0;
        end else if (tmr_tick_c) begin
          edge_d   = edge_nxt_c;
          sclk_d   = ~sclk_q;
          shift_d  = stb_c.shift;
          sample_d = stb_c.sample;
          if (last_edge_c) begin
            state_d = ST_TAIL;
            sclk_d  = mode_q[MODE_CPOL];
          end
        end
      end

      ST_TAIL: begin
        tmr_en_c = 1'b1;
        // abort wins over a completion landing in the same cycle
        if (bus.stop) begin
          state_d  = ST_IDLE;
          sclk_d   = bus.cpol;
          active_d = 1'b0;
        end else if (tmr_tick_c) begin
          state_d  = ST_IDLE;
          sclk_d   = bus.cpol;
          active_d = 1'b0;
          done_d   = 1'b1;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        active_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      nbits_q  <= '0;
      mode_q   <= '0;
      edge_q   <= '0;
      sclk_q   <= 1'b0;
      active_q <= 1'b0;
      shift_q  <= 1'b0;
      sample_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      nbits_q  <= nbits_d;
      mode_q   <= mode_d;
      edge_q   <= edge_d;
      sclk_q   <= sclk_d;
      active_q <= active_d;
      shift_q  <= shift_d;
      sample_q <= sample_d;
      done_q   <= done_d;
    end
  end

  assign bus.sclk       = sclk_q;
  assign bus.active     = active_q;
  assign bus.shift_stb  = shift_q;
  assign bus.sample_stb = sample_q;
  assign bus.done       = done_q;

endmodule

// File: doc/spi_sclk_engine.md
Name: spi_sclk_engine

Overview:
Parametrised successor of the single-mode SPI clock divider. Generates a programmable-length burst of SPI clock periods in any of the four SPI modes (CPOL/CPHA), with per-edge shift/sample strobes, a tail hold, abort, and a one-cycle done pulse. Sits between the frame sequencer and the shift-register datapath feeding the LED-matrix driver chain. Runs entirely on the system clock, with no derived-clock or XOR-clock logic.

Parameters:
DIV_W, 8, width of clk_div; half period H = clk_div + 1 system cycles.
CNT_W, 6, width of num_bits; bursts of 1 to 2^CNT_W - 1 SCLK periods.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  burst request, sampled only in IDLE
stop  in  1  abort request, honoured in any non-IDLE state
clk_div  in  DIV_W  half-period minus one, latched at start
num_bits  in  CNT_W  SCLK periods per burst, latched at start
cpol  in  1  SCLK idle level, latched at start (followed live in IDLE)
cpha  in  1  0: sample on leading edge; 1: shift on leading edge; latched at start
sclk  out  1  SPI clock, registered
active  out  1  burst in progress, registered
shift_stb  out  1  one-cycle pulse: datapath drives next bit
sample_stb  out  1  one-cycle pulse: datapath captures input bit
done  out  1  one-cycle pulse at normal burst completion

Behaviour:
- Reset (rst = 0, asynchronous): state IDLE, all counters 0, sclk = 0, active = 0, and all strobes and done = 0.
- IDLE: sclk follows cpol registered (one-cycle lag); active = 0.
- Start: in IDLE, start = 1, stop = 0, num_bits != 0 -> latch config; state RUN; active = 1 from the next edge (call it E0); div counter cleared.
- num_bits = 0 at start: request ignored; stays IDLE, no active, no done.
- start while not IDLE: ignored. Config inputs are don't-care outside IDLE.
- RUN: div counter counts 0..clk_div. On wrap, sclk toggles and the edge counter increments.
  - Edge k (k = 1..2N, N = latched num_bits) becomes visible at edge E0 + k*H.
  - Odd k = leading edge; even k = trailing edge.
- Strobes are high during the cycle in which sclk shows its new value:
  - cpha = 0: sample_stb on leading edges; shift_stb on trailing edges except k = 2N.
  - cpha = 1: shift_stb on leading edges; sample_stb on trailing edges.
- After edge 2N: state TAIL, sclk = cpol, hold H cycles.
- At E0 + (2N+1)*H: active = 0, done = 1 for one cycle, state IDLE.
- A new start is accepted in the cycle done is high; active re-asserts on the following edge.
- stop = 1 in RUN/TAIL: on the next edge go to IDLE, sclk = cpol, active = 0, strobes 0, no done. stop overrides the simultaneous completion (no done).
- start and stop both high in IDLE: ignored.
- clk_div = 0: H = 1; sclk toggles every cycle; strobes may be high on consecutive cycles.
- Arithmetic: div counter DIV_W bits, compare with ==. Edge counter CNT_W+1 bits, so 2N never overflows. No wrap beyond the terminal count.

Decomposition:
- Package spi_engine_pkg: state encoding (IDLE, RUN, TAIL), default DIV_W/CNT_W constants, mode-bit positions {cpol, cpha}.
- One sub-module: spi_half_period_timer (DIV_W counter, load/clear, one-cycle tick on terminal count), reused for the RUN edges and the TAIL hold.

Test Plan:
- Mode 0, clk_div = 1, num_bits = 2:
  - active rises at E0; sclk rises at E0+2 and E0+6, falls at E0+4 and E0+8.
  - sample_stb at E0+2 and E0+6; shift_stb at E0+4 only.
  - done at E0+10.
- Mode 3 (cpol = 1, cpha = 1), clk_div = 0, num_bits = 3:
  - sclk idle 1 and toggles each cycle for 6 cycles.
  - shift_stb on edges 1, 3, 5; sample_stb on edges 2, 4, 6.
  - done at E0+7.
- Abort: mode 0, clk_div = 3, num_bits = 4, stop asserted at E0+9:
  - next edge: active = 0, sclk = 0.
  - no done pulse; no strobes after the abort.
- Boundaries:
  - num_bits = 0 with start -> active never rises.
  - start pulsed during RUN -> the burst is unchanged.
  - cpol toggled mid-burst -> the burst is unaffected.
- Back-to-back: start held high through done -> the second burst's active rises on the edge after done, with one idle cycle.
- Reset mid-burst: rst low asynchronously between clock edges:
  - sclk, active and strobes drop to 0 immediately.
  - after release, the block is in IDLE and sclk follows cpol.
